// File: rtl/simplebus_reg_slave_if.sv
// Register-bus bundle between a bus master and simplebus_reg_slave.
// Handshake: bus_cmd_valid is a one-cycle strobe with no ready; the slave accepts every strobe at that posedge, and read data appears on bus_rd_data one cycle later, holding until the next read.
interface simplebus_reg_slave_if;
  logic        bus_cmd_valid;
  logic        bus_op;
  logic [15:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data;

  modport master (
    output bus_cmd_valid,
    output bus_op,
    output bus_addr,
    output bus_wr_data,
    input  bus_rd_data
  );

  modport slave (
    input  bus_cmd_valid,
    input  bus_op,
    input  bus_addr,
    input  bus_wr_data,
    output bus_rd_data
  );
endinterface

// File: rtl/simplebus_reg_slave.sv
// Register slave with a byte-stream pass/invert datapath, frame and byte counters.
// dbg_state exposes the frame FSM (0 = IDLE, 1 = FRAME).
module simplebus_reg_slave #(
  parameter logic [15:0] ID_VALUE = 16'h5B01,
  parameter logic [15:0] CTRL_RST = 16'h0002
) (
  input  logic                       clk,
  input  logic                       rst_n,
  simplebus_reg_slave_if.slave       bus,
  input  logic [7:0]                 rxd,
  input  logic                       rx_dv,
  output logic [7:0]                 txd,
  output logic                       tx_en,
  output logic                       dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam logic [15:0] ADDR_CTRL    = 16'h0000;
  localparam logic [15:0] ADDR_PKT_CNT = 16'h0001;
  localparam logic [15:0] ADDR_BYTE_CNT= 16'h0002;
  localparam logic [15:0] ADDR_ID      = 16'h0003;
  localparam logic [15:0] ADDR_SCRATCH = 16'h0004;

  state_t      state_q, state_d;
  logic [1:0]  ctrl_q;
  logic [15:0] scratch_q;
  logic [15:0] pkt_cnt_q;
  logic [15:0] byte_cnt_q;
  logic        frame_pass_q, frame_inv_q;
  logic        frame_start, frame_end;
  logic        pass_eff, inv_eff;
  logic        wr_en, rd_en;
  logic [15:0] rd_mux;

  assign wr_en = bus.bus_cmd_valid & bus.bus_op;
  assign rd_en = bus.bus_cmd_valid & ~bus.bus_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_dv) begin
          state_d     = FRAME;
          frame_start = 1'b1;
        end
      end
      FRAME: begin
        if (!rx_dv) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = (state_q == FRAME);

  // The first byte uses live CTRL; later bytes use the copy latched at frame start.
  assign pass_eff = frame_start ? ctrl_q[1] : frame_pass_q;
  assign inv_eff  = frame_start ? ctrl_q[0] : frame_inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_pass_q <= CTRL_RST[1];
      frame_inv_q  <= CTRL_RST[0];
    end else if (frame_start) begin
      frame_pass_q <= ctrl_q[1];
      frame_inv_q  <= ctrl_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_en <= 1'b0;
      txd   <= 8'h00;
    end else begin
      tx_en <= rx_dv & pass_eff;
      if (rx_dv && pass_eff) txd <= inv_eff ? ~rxd : rxd;
      else                   txd <= 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= CTRL_RST[1:0];
      scratch_q <= 16'h0000;
    end else if (wr_en) begin
      if (bus.bus_addr == ADDR_CTRL)    ctrl_q    <= bus.bus_wr_data[1:0];
      if (bus.bus_addr == ADDR_SCRATCH) scratch_q <= bus.bus_wr_data;
    end
  end

  // A clearing write outranks a same-edge increment on both counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= 16'h0000;
      byte_cnt_q <= 16'h0000;
    end else begin
      if (wr_en && bus.bus_addr == ADDR_PKT_CNT)   pkt_cnt_q <= 16'h0000;
      else if (frame_end && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'h0001;

      if (wr_en && bus.bus_addr == ADDR_BYTE_CNT)  byte_cnt_q <= 16'h0000;
      else if (rx_dv)                              byte_cnt_q <= byte_cnt_q + 16'h0001;
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (bus.bus_addr)
      ADDR_CTRL:     rd_mux = {14'h0000, ctrl_q};
      ADDR_PKT_CNT:  rd_mux = pkt_cnt_q;
      ADDR_BYTE_CNT: rd_mux = byte_cnt_q;
      ADDR_ID:       rd_mux = ID_VALUE;
      ADDR_SCRATCH:  rd_mux = scratch_q;
      default:       rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     bus.bus_rd_data <= 16'h0000;
    else if (rd_en) bus.bus_rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_simplebus_reg_slave.sv
// Directed bench for simplebus_reg_slave: register access, frame datapath, counters and reset.
module tb_simplebus_reg_slave;
  logic       clk;
  logic       rst_n;
  logic [7:0] rxd;
  logic       rx_dv;
  logic [7:0] txd;
  logic       tx_en;
  logic       dbg_state;
  int         checks;
  int         errors;

  simplebus_reg_slave_if bus();

  simplebus_reg_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rxd       (rxd),
    .rx_dv     (rx_dv),
    .txd       (txd),
    .tx_en     (tx_en),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.bus_cmd_valid = 1'b1; bus.bus_op = 1'b1; bus.bus_addr = a; bus.bus_wr_data = d;
    @(negedge clk);
    bus.bus_cmd_valid = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.bus_cmd_valid = 1'b1; bus.bus_op = 1'b0; bus.bus_addr = a;
    @(negedge clk);
    bus.bus_cmd_valid = 1'b0;
    d = bus.bus_rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rx_dv = 1'b0; rxd = 8'h00;
    bus.bus_cmd_valid = 1'b0; bus.bus_op = 1'b0; bus.bus_addr = 16'h0; bus.bus_wr_data = 16'h0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.bus_rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got %h exp 0000", bus.bus_rd_data); end
    checks++; if (txd !== 8'h00) begin errors++; $display("FAIL reset_txd got %h exp 00", txd); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b exp 0", tx_en); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", dbg_state); end
    @(negedge clk); @(negedge clk);
    // command presented together with release is taken on the first posedge
    rst_n = 1'b1;
    bus.bus_cmd_valid = 1'b1; bus.bus_op = 1'b0; bus.bus_addr = 16'h0003;
    @(negedge clk);
    bus.bus_cmd_valid = 1'b0;
    checks++; if (bus.bus_rd_data !== 16'h5B01) begin errors++; $display("FAIL first_cmd_id got %h exp 5B01", bus.bus_rd_data); end
  endtask

  task automatic test_id_read();
    logic [15:0] d;
    bus_read(16'h0000, d);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL read_ctrl got %h exp 0002", d); end
    bus_read(16'h0003, d);
    checks++; if (d !== 16'h5B01) begin errors++; $display("FAIL read_id got %h exp 5B01", d); end
    bus_read(16'h0004, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL read_scratch got %h exp 0000", d); end
  endtask

  task automatic test_regs();
    logic [15:0] d;
    bus_write(16'h0004, 16'hA5C3);
    bus_read(16'h0004, d);
    checks++; if (d !== 16'hA5C3) begin errors++; $display("FAIL scratch_rw got %h exp A5C3", d); end
    bus_write(16'h0003, 16'h1234);
    repeat (2) @(negedge clk);
    checks++; if (bus.bus_rd_data !== 16'hA5C3) begin errors++; $display("FAIL rd_hold got %h exp A5C3", bus.bus_rd_data); end
    bus_read(16'h0003, d);
    checks++; if (d !== 16'h5B01) begin errors++; $display("FAIL id_ro got %h exp 5B01", d); end
    bus_read(16'h00FF, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped got %h exp 0000", d); end
    bus_write(16'h0000, 16'hFFFF);
    bus_read(16'h0000, d);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL ctrl_mask got %h exp 0003", d); end
  endtask

  task automatic test_invert();
    logic [15:0] d;
    logic       sdv [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] sd  [4]  = '{8'h00, 8'h0F, 8'hF0, 8'h00};
    logic       een [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] etx [4]  = '{8'hFF, 8'hF0, 8'h0F, 8'h00};
    bus_write(16'h0000, 16'h0003);
    bus_write(16'h0001, 16'h0000);
    bus_write(16'h0002, 16'h0000);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (tx_en !== een[i-1]) begin errors++; $display("FAIL inv_tx_en[%0d] got %b exp %b", i-1, tx_en, een[i-1]); end
        checks++; if (txd !== etx[i-1]) begin errors++; $display("FAIL inv_txd[%0d] got %h exp %h", i-1, txd, etx[i-1]); end
      end
      if (i < 4) begin rx_dv = sdv[i]; rxd = sd[i]; end
    end
    bus_read(16'h0001, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL inv_pkt_cnt got %h exp 0001", d); end
    bus_read(16'h0002, d);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL inv_byte_cnt got %h exp 0003", d); end
  endtask

  task automatic test_ctrl_latch();
    logic [15:0] d;
    logic       sdv [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] sd  [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h55, 8'h66, 8'h77, 8'h00};
    logic       een [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] etx [9] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bus_write(16'h0000, 16'h0002);
    bus_write(16'h0001, 16'h0000);
    bus_write(16'h0002, 16'h0000);
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (tx_en !== een[i-1]) begin errors++; $display("FAIL latch_tx_en[%0d] got %b exp %b", i-1, tx_en, een[i-1]); end
        checks++; if (txd !== etx[i-1]) begin errors++; $display("FAIL latch_txd[%0d] got %h exp %h", i-1, txd, etx[i-1]); end
      end
      bus.bus_cmd_valid = (i == 1);
      bus.bus_op = 1'b1; bus.bus_addr = 16'h0000; bus.bus_wr_data = 16'h0000;
      if (i < 9) begin rx_dv = sdv[i]; rxd = sd[i]; end
    end
    bus.bus_cmd_valid = 1'b0;
    bus_read(16'h0001, d);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL b2b_pkt_cnt got %h exp 0002", d); end
    bus_read(16'h0002, d);
    checks++; if (d !== 16'h0007) begin errors++; $display("FAIL b2b_byte_cnt got %h exp 0007", d); end
  endtask

  task automatic test_first_byte_write();
    // CTRL is 0 here; a write on the first byte must not affect that frame
    @(negedge clk);
    rx_dv = 1'b1; rxd = 8'h3C;
    bus.bus_cmd_valid = 1'b1; bus.bus_op = 1'b1; bus.bus_addr = 16'h0000; bus.bus_wr_data = 16'h0002;
    @(negedge clk);
    bus.bus_cmd_valid = 1'b0; rxd = 8'hC3;
    checks++; if (tx_en !== 1'b0 || txd !== 8'h00) begin errors++; $display("FAIL fb_byte0 got %b/%h exp 0/00", tx_en, txd); end
    @(negedge clk);
    rx_dv = 1'b0;
    checks++; if (tx_en !== 1'b0 || txd !== 8'h00) begin errors++; $display("FAIL fb_byte1 got %b/%h exp 0/00", tx_en, txd); end
    @(negedge clk);
    rx_dv = 1'b1; rxd = 8'h5A;
    @(negedge clk);
    rx_dv = 1'b0;
    checks++; if (tx_en !== 1'b1 || txd !== 8'h5A) begin errors++; $display("FAIL fb_next_frame got %b/%h exp 1/5a", tx_en, txd); end
    @(negedge clk);
    checks++; if (tx_en !== 1'b0 || txd !== 8'h00) begin errors++; $display("FAIL fb_idle got %b/%h exp 0/00", tx_en, txd); end
  endtask

  task automatic test_wrap_and_clear();
    logic [15:0] d;
    bus_write(16'h0002, 16'h0000);
    for (int i = 0; i < 65537; i++) begin
      @(negedge clk);
      rx_dv = 1'b1; rxd = 8'(i);
    end
    // frame-end edge coincides with a PKT_CNT clear
    @(negedge clk);
    rx_dv = 1'b0;
    bus.bus_cmd_valid = 1'b1; bus.bus_op = 1'b1; bus.bus_addr = 16'h0001; bus.bus_wr_data = 16'hBEEF;
    @(negedge clk);
    bus.bus_cmd_valid = 1'b0;
    bus_read(16'h0002, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL byte_wrap got %h exp 0001", d); end
    bus_read(16'h0001, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL pkt_clear_wins got %h exp 0000", d); end
    @(negedge clk);
    rx_dv = 1'b1; rxd = 8'h99;
    bus.bus_cmd_valid = 1'b1; bus.bus_op = 1'b1; bus.bus_addr = 16'h0002; bus.bus_wr_data = 16'h0000;
    @(negedge clk);
    rx_dv = 1'b0; bus.bus_cmd_valid = 1'b0;
    bus_read(16'h0002, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL byte_clear_wins got %h exp 0000", d); end
    bus_read(16'h0001, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL pkt_after_clear got %h exp 0001", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] d;
    bus_write(16'h0000, 16'h0003);
    @(negedge clk);
    rx_dv = 1'b1; rxd = 8'h01;
    @(negedge clk);
    rxd = 8'h02;
    checks++; if (tx_en !== 1'b1 || txd !== 8'hFE) begin errors++; $display("FAIL rmf_byte0 got %b/%h exp 1/fe", tx_en, txd); end
    @(negedge clk);
    rxd = 8'h03;
    checks++; if (tx_en !== 1'b1 || txd !== 8'hFD) begin errors++; $display("FAIL rmf_byte1 got %b/%h exp 1/fd", tx_en, txd); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_en !== 1'b0 || txd !== 8'h00) begin errors++; $display("FAIL rmf_async got %b/%h exp 0/00", tx_en, txd); end
    checks++; if (bus.bus_rd_data !== 16'h0000) begin errors++; $display("FAIL rmf_rd_data got %h exp 0000", bus.bus_rd_data); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL rmf_state got %b exp 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1; rx_dv = 1'b0;
    bus_read(16'h0001, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rmf_pkt_cnt got %h exp 0000", d); end
    bus_read(16'h0002, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL rmf_byte_cnt got %h exp 0000", d); end
    bus_read(16'h0000, d);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL rmf_ctrl got %h exp 0002", d); end
    @(negedge clk);
    rx_dv = 1'b1; rxd = 8'hA5;
    @(negedge clk);
    rx_dv = 1'b0;
    checks++; if (tx_en !== 1'b1 || txd !== 8'hA5) begin errors++; $display("FAIL rmf_new_frame got %b/%h exp 1/a5", tx_en, txd); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_id_read();
    test_regs();
    test_invert();
    test_ctrl_latch();
    test_first_byte_write();
    test_wrap_and_clear();
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
